l3_share_arbiter: RTL and testbench

- Arbitrates the shared central L3 register grid between the per-core datapath blocks.
- Round-robin grant; captures one request (single beat or short burst); drives the L3 access port; routes read data and completion back to the winner.
- Sits between the core blocks and the L3 array. Backpressure from L3 via l3_ready. Watchdog aborts stalled accesses.

---
 rtl/l3_share_arbiter.sv | 171 +++++++++++++++++
 tb/tb_l3_share_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l3_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : l3_share_arbiter
// Brief   : Round-robin arbiter that grants the shared L3 register grid to one
//           core at a time for single-beat or short-burst accesses.
// Revision: 1.0 - initial release
// ============================================================================
module l3_share_arbiter #(
    parameter int NUM_REQ = 6,
    parameter int ADDR_W  = 12,
    parameter int DEPTH   = 3600,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*2-1:0]        req_len,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        beat_ack,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic                        l3_en,
    output logic                        l3_we,
    output logic [ADDR_W-1:0]           l3_addr,
    output logic [DATA_W-1:0]           l3_wdata,
    input  logic                        l3_ready,
    input  logic [DATA_W-1:0]           l3_rdata,
    output logic                        busy
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    logic [1:0]        r_state;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_left;
    logic [WD_W-1:0]   r_wdog;
    logic              r_rsp_vld;
    logic              r_rsp_rd;
    logic              r_rsp_err;
    logic [ID_W-1:0]   r_rsp_id;

    logic              w_found;
    logic [ID_W-1:0]   w_win;
    logic [ID_W-1:0]   w_cand;
    logic [ADDR_W-1:0] w_cap_addr;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_xfer;
    logic              w_err;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = ID_W'((int'(r_ptr) + i) % NUM_REQ);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_cap_addr  = req_addr[int'(w_win)*ADDR_W +: ADDR_W];
    assign w_next_addr = (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
    assign w_xfer      = (r_state == S_XFER);
    assign w_err       = (r_state == S_ERR);

    assign busy      = (r_state != S_IDLE);
    assign l3_en     = w_xfer;
    assign l3_we     = w_xfer & r_we;
    assign l3_addr   = w_xfer ? r_addr : '0;
    assign l3_wdata  = w_xfer ? req_wdata[int'(r_owner)*DATA_W +: DATA_W] : '0;
    assign beat_ack  = w_xfer & l3_ready;
    assign rsp_err   = r_rsp_err | w_err;
    assign rsp_rdata = r_rsp_rd ? l3_rdata : '0;

    always_comb begin
        gnt = '0;
        if (busy) gnt[r_owner] = 1'b1;
    end

    // A trailing response uses its own registered id, independent of the owner.
    always_comb begin
        rsp_valid = '0;
        if (r_rsp_vld) rsp_valid[r_rsp_id] = 1'b1;
        if (w_err)     rsp_valid[r_owner]  = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_left    <= '0;
            r_wdog    <= '0;
            r_rsp_vld <= 1'b0;
            r_rsp_rd  <= 1'b0;
            r_rsp_err <= 1'b0;
            r_rsp_id  <= '0;
        end else begin
            r_rsp_vld <= 1'b0;
            r_rsp_rd  <= 1'b0;
            r_rsp_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_win;
                        r_we    <= req_we[w_win];
                        r_addr  <= w_cap_addr;
                        r_left  <= req_len[int'(w_win)*2 +: 2];
                        r_wdog  <= '0;
                        r_ptr   <= (w_win == LAST_ID) ? '0 : w_win + 1'b1;
                        r_state <= (w_cap_addr > LAST_ADDR) ? S_ERR : S_XFER;
                    end
                end
                S_XFER: begin
                    if (l3_ready) begin
                        r_wdog   <= '0;
                        r_addr   <= w_next_addr;
                        r_left   <= r_left - 1'b1;
                        r_rsp_id <= r_owner;
                        if (!r_we) begin
                            r_rsp_vld <= 1'b1;
                            r_rsp_rd  <= 1'b1;
                        end
                        if (r_left == 2'd0) begin
                            r_state <= S_IDLE;
                            if (r_we) r_rsp_vld <= 1'b1;
                        end
                    end else if (r_wdog == WD_LAST) begin
                        // Stalled too long: abandon remaining beats and report.
                        r_state   <= S_IDLE;
                        r_rsp_vld <= 1'b1;
                        r_rsp_err <= 1'b1;
                        r_rsp_id  <= r_owner;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                S_ERR: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l3_share_arbiter.sv
`default_nettype none
// Testbench for l3_share_arbiter: scenario tasks plus a response scoreboard.
module tb_l3_share_arbiter;

    localparam int NUM_REQ = 6;
    localparam int ADDR_W  = 12;
    localparam int DEPTH   = 3600;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 15;

    typedef logic [NUM_REQ+DATA_W:0] rsp_t;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*2-1:0]      req_len;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic                      beat_ack;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic                      l3_en;
    logic                      l3_we;
    logic [ADDR_W-1:0]         l3_addr;
    logic [DATA_W-1:0]         l3_wdata;
    logic                      l3_ready;
    logic [DATA_W-1:0]         l3_rdata;
    logic                      busy;

    int   total = 0;
    int   bad   = 0;
    rsp_t exp_q[$];

    l3_share_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_len(req_len), .req_wdata(req_wdata), .gnt(gnt), .beat_ack(beat_ack),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .l3_en(l3_en), .l3_we(l3_we), .l3_addr(l3_addr), .l3_wdata(l3_wdata),
        .l3_ready(l3_ready), .l3_rdata(l3_rdata), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DATA_W-1:0] rd_pat(input logic [ADDR_W-1:0] a);
        if (a == 12'd5) return 16'hBEEF;
        return {4'hC, a};
    endfunction

    // L3 array model: read data one cycle after an accepted read.
    always @(posedge clk) begin
        l3_rdata <= (l3_en && l3_ready && !l3_we) ? rd_pat(l3_addr) : 16'h0;
    end

    // Scoreboard: every response strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (rst !== 1'b1 && rsp_valid !== '0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got valid=%b rdata=%h err=%b, required no response",
                         rsp_valid, rsp_rdata, rsp_err);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                if ({rsp_valid, rsp_rdata, rsp_err} !== e) begin
                    bad++;
                    $display("FAIL rsp_scoreboard: got valid=%b rdata=%h err=%b, required valid=%b rdata=%h err=%b",
                             rsp_valid, rsp_rdata, rsp_err, e[22:17], e[16:1], e[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic set_core(input int k, input logic we, input logic [ADDR_W-1:0] a,
                            input logic [1:0] len, input logic [DATA_W-1:0] wd);
        req_we[k]                    = we;
        req_addr[k*ADDR_W +: ADDR_W] = a;
        req_len[k*2 +: 2]            = len;
        req_wdata[k*DATA_W +: DATA_W] = wd;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_len = '0;
        req_wdata = '0; l3_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (gnt !== '0) begin bad++; $display("FAIL reset_gnt: got %b want 0", gnt); end
        total++; if (busy !== 1'b0 || l3_en !== 1'b0) begin bad++; $display("FAIL reset_busy_en: got busy=%b en=%b want 0", busy, l3_en); end
        total++; if (rsp_valid !== '0 || rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp: got valid=%b err=%b want 0", rsp_valid, rsp_err); end
        total++; if (l3_addr !== '0 || l3_wdata !== '0 || beat_ack !== 1'b0) begin bad++; $display("FAIL reset_l3: got addr=%h wdata=%h ack=%b want 0", l3_addr, l3_wdata, beat_ack); end
        rst = 1'b0;
    endtask

    task automatic test_single_read;
        @(posedge clk); #1;
        set_core(2, 1'b0, 12'd5, 2'd0, 16'h0);
        req = 6'b000100; l3_ready = 1'b1;
        exp_q.push_back({6'b000100, 16'hBEEF, 1'b0});
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd_c0_busy: got %b want 0", busy); end
        @(negedge clk);
        total++; if (gnt !== 6'b000100) begin bad++; $display("FAIL rd_c1_gnt: got %b want 000100", gnt); end
        total++; if (l3_en !== 1'b1 || l3_we !== 1'b0 || l3_addr !== 12'd5) begin bad++; $display("FAIL rd_c1_l3: got en=%b we=%b addr=%0d want 1 0 5", l3_en, l3_we, l3_addr); end
        req = '0;
        @(negedge clk);
        total++; if (rsp_valid !== 6'b000100 || rsp_rdata !== 16'hBEEF) begin bad++; $display("FAIL rd_c2_rsp: got valid=%b rdata=%h want 000100 beef", rsp_valid, rsp_rdata); end
        total++; if (busy !== 1'b0 || gnt !== '0) begin bad++; $display("FAIL rd_c2_idle: got busy=%b gnt=%b want 0", busy, gnt); end
    endtask

    task automatic test_round_robin;
        int n = 0;
        int cyc = 0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < NUM_REQ; k++) set_core(k, 1'b0, 12'(10 + k), 2'd0, 16'h0);
        for (int n2 = 0; n2 < 7; n2++)
            exp_q.push_back({6'(6'b1 << (n2 % 6)), rd_pat(12'(10 + (n2 % 6))), 1'b0});
        req = '1; l3_ready = 1'b1;
        while (n < 7 && cyc < 40) begin
            @(negedge clk); cyc++;
            if (gnt !== '0) begin
                total++;
                if (gnt !== 6'(6'b1 << (n % 6))) begin
                    bad++; $display("FAIL rr_order_%0d: got %b want %b", n, gnt, 6'(6'b1 << (n % 6)));
                end
                n++;
                if (n == 7) req = '0;
            end
        end
        if (n < 7) begin total++; bad++; $display("FAIL rr_timeout: got %0d grants want 7", n); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_burst;
        int rdy[5] = '{1, 0, 1, 1, 1};
        int ea[5]  = '{3598, 3599, 3599, 0, 1};
        int b = 0;
        int acks = 0;
        exp_q.push_back({6'b000010, 16'h0, 1'b0});
        @(posedge clk); #1;
        set_core(1, 1'b1, 12'd3598, 2'd3, 16'h1000);
        req = 6'b000010; l3_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            l3_ready = rdy[i] ? 1'b1 : 1'b0;
            req_wdata[1*DATA_W +: DATA_W] = 16'(16'h1000 + b);
            @(negedge clk);
            if (i == 0) begin
                total++; if (gnt !== 6'b000010) begin bad++; $display("FAIL wr_gnt: got %b want 000010", gnt); end
                req = '0;
            end
            total++;
            if (l3_addr !== 12'(ea[i]) || l3_we !== 1'b1 || l3_wdata !== 16'(16'h1000 + b)) begin
                bad++; $display("FAIL wr_beat_%0d: got addr=%0d we=%b wdata=%h want addr=%0d we=1 wdata=%h",
                                i, l3_addr, l3_we, l3_wdata, ea[i], 16'(16'h1000 + b));
            end
            if (beat_ack === 1'b1) begin acks++; b++; end
        end
        @(posedge clk); #1; l3_ready = 1'b1;
        @(negedge clk);
        total++; if (acks != 4) begin bad++; $display("FAIL wr_ack_count: got %0d want 4", acks); end
        total++; if (rsp_valid !== 6'b000010 || rsp_err !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL wr_done: got valid=%b err=%b busy=%b want 000010 0 0", rsp_valid, rsp_err, busy); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_bad_addr;
        int n = 0;
        int cyc = 0;
        int order[2] = '{5, 0};
        exp_q.push_back({6'b010000, 16'h0, 1'b1});
        @(posedge clk); #1;
        set_core(4, 1'b0, 12'd3600, 2'd0, 16'h0);
        req = 6'b010000; l3_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (gnt !== 6'b010000 || l3_en !== 1'b0) begin bad++; $display("FAIL err_c1: got gnt=%b en=%b want 010000 0", gnt, l3_en); end
        total++; if (rsp_valid !== 6'b010000 || rsp_err !== 1'b1) begin bad++; $display("FAIL err_rsp: got valid=%b err=%b want 010000 1", rsp_valid, rsp_err); end
        req = '0;
        @(negedge clk);
        total++; if (gnt !== '0 || busy !== 1'b0) begin bad++; $display("FAIL err_c2: got gnt=%b busy=%b want 0 0", gnt, busy); end
        // Pointer should now sit at 5, so core 5 beats core 0.
        @(posedge clk); #1;
        set_core(0, 1'b0, 12'd20, 2'd0, 16'h0);
        set_core(5, 1'b0, 12'd21, 2'd0, 16'h0);
        exp_q.push_back({6'b100000, rd_pat(12'd21), 1'b0});
        exp_q.push_back({6'b000001, rd_pat(12'd20), 1'b0});
        req = 6'b100001;
        while (n < 2 && cyc < 20) begin
            @(negedge clk); cyc++;
            if (gnt !== '0) begin
                total++;
                if (gnt !== 6'(6'b1 << order[n])) begin bad++; $display("FAIL ptr_order_%0d: got %b want %b", n, gnt, 6'(6'b1 << order[n])); end
                req = req & ~gnt;
                n++;
            end
        end
        if (n < 2) begin total++; bad++; $display("FAIL ptr_timeout: got %0d grants want 2", n); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout;
        int stall = 0;
        exp_q.push_back({6'b000001, 16'h0, 1'b1});
        @(posedge clk); #1;
        set_core(0, 1'b0, 12'd7, 2'd0, 16'h0);
        req = 6'b000001; l3_ready = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= TIMEOUT; i++) begin
            @(negedge clk);
            if (l3_en === 1'b1 && gnt === 6'b000001) stall++;
            if (i == 1) req = '0;
        end
        total++; if (stall != TIMEOUT) begin bad++; $display("FAIL to_stall_cycles: got %0d want %0d", stall, TIMEOUT); end
        @(negedge clk);
        total++; if (l3_en !== 1'b0 || gnt !== '0) begin bad++; $display("FAIL to_abort: got en=%b gnt=%b want 0 0", l3_en, gnt); end
        total++; if (rsp_valid !== 6'b000001 || rsp_err !== 1'b1) begin bad++; $display("FAIL to_rsp: got valid=%b err=%b want 000001 1", rsp_valid, rsp_err); end
        @(negedge clk);
        total++; if (l3_en !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL to_after: got en=%b busy=%b want 0 0", l3_en, busy); end
        l3_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_burst;
        int cyc = 0;
        logic seen5 = 1'b0;
        @(posedge clk); #1;
        set_core(4, 1'b1, 12'd100, 2'd3, 16'h2222);
        req = 6'b010000; l3_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (gnt !== 6'b010000) begin bad++; $display("FAIL mid_gnt: got %b want 010000", gnt); end
        req = '0;
        @(posedge clk); #1;
        total++; if (l3_en !== 1'b1) begin bad++; $display("FAIL mid_active: got en=%b want 1", l3_en); end
        rst = 1'b1;
        #1;
        total++; if (gnt !== '0 || l3_en !== 1'b0 || busy !== 1'b0 || beat_ack !== 1'b0) begin bad++; $display("FAIL mid_rst_ctl: got gnt=%b en=%b busy=%b ack=%b want 0", gnt, l3_en, busy, beat_ack); end
        total++; if (rsp_valid !== '0 || rsp_err !== 1'b0 || rsp_rdata !== '0) begin bad++; $display("FAIL mid_rst_rsp: got valid=%b err=%b rdata=%h want 0", rsp_valid, rsp_err, rsp_rdata); end
        total++; if (l3_addr !== '0 || l3_wdata !== '0 || l3_we !== 1'b0) begin bad++; $display("FAIL mid_rst_l3: got addr=%h wdata=%h we=%b want 0", l3_addr, l3_wdata, l3_we); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        set_core(3, 1'b0, 12'd30, 2'd0, 16'h0);
        set_core(5, 1'b0, 12'd31, 2'd0, 16'h0);
        exp_q.push_back({6'b001000, rd_pat(12'd30), 1'b0});
        exp_q.push_back({6'b100000, rd_pat(12'd31), 1'b0});
        req = 6'b101000;
        @(negedge clk);
        total++; if (gnt !== '0) begin bad++; $display("FAIL post_c0: got %b want 0", gnt); end
        @(negedge clk);
        total++; if (gnt !== 6'b001000) begin bad++; $display("FAIL post_c1_gnt: got %b want 001000", gnt); end
        req[3] = 1'b0;
        while (!seen5 && cyc < 10) begin
            @(negedge clk); cyc++;
            if (gnt === 6'b100000) begin seen5 = 1'b1; req[5] = 1'b0; end
        end
        total++; if (!seen5) begin bad++; $display("FAIL post_gnt5: got no grant want 100000"); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_burst();
        test_bad_addr();
        test_timeout();
        test_reset_mid_burst();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL rsp_missing: got %0d outstanding want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
